// File: rtl/aesl_deadlock_pkg.sv
// Shared types and default constants for the AXIS deadlock watchdog.
package aesl_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        REPORT,
        HOLD
    } wd_state_e;

    localparam int DEF_NUM_AXIS = 3;
    localparam int DEF_THRESH   = 1024;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_TS_W     = 32;

endpackage

// File: rtl/aesl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module aesl_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] MAX = '1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/aesl_deadlock_watchdog.sv
// Debounces the deadlock monitor's block flag, latches one report record
// and hands it over valid/ready, then holds a sticky flag until cleared.
module aesl_deadlock_watchdog
    import aesl_deadlock_pkg::*;
#(
    parameter int NUM_AXIS = DEF_NUM_AXIS,
    parameter int THRESH   = DEF_THRESH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int TS_W     = DEF_TS_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                block_in,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic                clear,
    output logic                report_valid,
    input  logic                report_ready,
    output logic [NUM_AXIS-1:0] report_chan_mask,
    output logic [TS_W-1:0]     report_ts,
    output logic                deadlock_found,
    output logic [CNT_W-1:0]    stall_cnt
);

    localparam logic [CNT_W:0] THRESH_V   = (CNT_W+1)'(THRESH);
    localparam bit             THRESH_ONE = (THRESH == 1);

    wd_state_e           state;
    wd_state_e           state_nxt;
    logic [TS_W-1:0]     ts;
    logic [NUM_AXIS-1:0] acc;
    logic [NUM_AXIS-1:0] acc_nxt;
    logic                cnt_inc;
    logic                cnt_clr;
    logic                capture;
    logic [CNT_W:0]      cnt_plus1;

    assign cnt_plus1 = {1'b0, stall_cnt} + 1'b1;

    aesl_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (cnt_inc),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_inc   = 1'b0;
        cnt_clr   = 1'b0;
        capture   = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
            acc_nxt   = '0;
            cnt_clr   = 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (block_in) begin
                        cnt_inc = 1'b1;
                        acc_nxt = axis_block_sigs;
                        if (THRESH_ONE) begin
                            capture   = 1'b1;
                            state_nxt = REPORT;
                        end else begin
                            state_nxt = COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (block_in) begin
                        cnt_inc = 1'b1;
                        acc_nxt = acc | axis_block_sigs;
                        if (cnt_plus1 == THRESH_V) begin
                            capture   = 1'b1;
                            state_nxt = REPORT;
                        end
                    end else begin
                        cnt_clr   = 1'b1;
                        acc_nxt   = '0;
                        state_nxt = IDLE;
                    end
                end
                // block_in is deliberately ignored until the record is taken
                REPORT: begin
                    if (report_valid && report_ready) begin
                        state_nxt = HOLD;
                    end
                end
                HOLD: begin
                    cnt_inc = block_in;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            ts               <= '0;
            acc              <= '0;
            report_valid     <= 1'b0;
            deadlock_found   <= 1'b0;
            report_chan_mask <= '0;
            report_ts        <= '0;
        end else begin
            state          <= state_nxt;
            ts             <= ts + 1'b1;
            acc            <= acc_nxt;
            report_valid   <= (state_nxt == REPORT);
            deadlock_found <= (state_nxt == REPORT) ||
                              (state_nxt == HOLD);
            if (capture) begin
                report_chan_mask <= acc_nxt;
                report_ts        <= ts;
            end
        end
    end

endmodule

// File: tb/tb_aesl_deadlock_watchdog.sv
// Directed bench: THRESH=8 instance with a report scoreboard, plus a
// THRESH=1 narrow instance for saturation, ts wrap and async reset.
module tb_aesl_deadlock_watchdog;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst8, block8, clear8, ready8;
    logic [2:0]  sigs8;
    logic        v8, found8;
    logic [2:0]  mask8;
    logic [31:0] ts8;
    logic [15:0] cnt8;

    logic        rst1, block1, clear1, ready1;
    logic [2:0]  sigs1;
    logic        v1, found1;
    logic [2:0]  mask1;
    logic [3:0]  ts1;
    logic [1:0]  cnt1;

    aesl_deadlock_watchdog #(
        .NUM_AXIS (3),
        .THRESH   (8),
        .CNT_W    (16),
        .TS_W     (32)
    ) dut8 (
        .clock            (clock),
        .reset            (rst8),
        .block_in         (block8),
        .axis_block_sigs  (sigs8),
        .clear            (clear8),
        .report_valid     (v8),
        .report_ready     (ready8),
        .report_chan_mask (mask8),
        .report_ts        (ts8),
        .deadlock_found   (found8),
        .stall_cnt        (cnt8)
    );

    aesl_deadlock_watchdog #(
        .NUM_AXIS (3),
        .THRESH   (1),
        .CNT_W    (2),
        .TS_W     (4)
    ) dut1 (
        .clock            (clock),
        .reset            (rst1),
        .block_in         (block1),
        .axis_block_sigs  (sigs1),
        .clear            (clear1),
        .report_valid     (v1),
        .report_ready     (ready1),
        .report_chan_mask (mask1),
        .report_ts        (ts1),
        .deadlock_found   (found1),
        .stall_cnt        (cnt1)
    );

    typedef struct {
        logic [2:0]  mask;
        logic [31:0] ts;
    } rec_t;

    rec_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          accepts = 0;
    int unsigned cyc8, cyc1;

    // cycle references for hand-computing expected timestamps
    always @(posedge clock or negedge rst8)
        if (!rst8) cyc8 <= 0;
        else       cyc8 <= cyc8 + 1;

    always @(posedge clock or negedge rst1)
        if (!rst1) cyc1 <= 0;
        else       cyc1 <= cyc1 + 1;

    task automatic chk(input string name, input int unsigned act,
                       input int unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // scoreboard monitor: every accepted record must match the queue head
    rec_t got;
    always @(negedge clock) begin
        if (rst8 && v8 && ready8) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_report: mask=%0h ts=%0h",
                         mask8, ts8);
            end else begin
                got = exp_q.pop_front();
                chk("sb_mask", 32'(mask8), 32'(got.mask));
                chk("sb_ts", ts8, got.ts);
                accepts++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    int unsigned e_ts;
    int          unstable;
    int          k;

    initial begin
        rst8 = 0; block8 = 0; clear8 = 0; ready8 = 0; sigs8 = '0;
        rst1 = 0; block1 = 0; clear1 = 0; ready1 = 0; sigs1 = '0;
        step(2);
        chk("rst_valid", 32'(v8), 0);
        chk("rst_found", 32'(found8), 0);
        chk("rst_cnt", 32'(cnt8), 0);
        chk("rst_mask", 32'(mask8), 0);
        chk("rst_ts", ts8, 0);
        @(negedge clock);
        rst8 = 1;
        step(1);

        // T1: 7 blocked cycles is below threshold
        block8 = 1; sigs8 = 3'b001;
        step(7);
        chk("t1_cnt7", 32'(cnt8), 7);
        chk("t1_novalid", 32'(v8), 0);
        block8 = 0;
        step(1);
        chk("t1_cnt0", 32'(cnt8), 0);
        chk("t1_novalid2", 32'(v8), 0);

        // T2: 8 blocked cycles declares deadlock
        block8 = 1; sigs8 = 3'b010;
        step(7);
        e_ts = cyc8;
        exp_q.push_back('{mask: 3'b010, ts: e_ts});
        step(1);
        chk("t2_valid", 32'(v8), 1);
        chk("t2_found", 32'(found8), 1);
        chk("t2_cnt", 32'(cnt8), 8);
        chk("t2_mask", 32'(mask8), 32'b010);
        chk("t2_ts", ts8, e_ts);

        // T4: back-pressure keeps the record stable
        block8 = 0;
        unstable = 0;
        repeat (20) begin
            step(1);
            if (v8 !== 1'b1 || mask8 !== 3'b010 || ts8 !== e_ts)
                unstable++;
        end
        chk("t4_stable", 32'(unstable), 0);
        chk("t4_cnt_ignored", 32'(cnt8), 8);
        ready8 = 1;
        step(1);
        ready8 = 0;
        chk("t4_valid_drop", 32'(v8), 0);
        chk("t4_found", 32'(found8), 1);
        chk("t4_accepts", 32'(accepts), 1);
        block8 = 1;
        step(3);
        chk("hold_cnt", 32'(cnt8), 11);

        // T5: clear in HOLD
        clear8 = 1; block8 = 0;
        step(1);
        clear8 = 0;
        chk("t5h_found", 32'(found8), 0);
        chk("t5h_valid", 32'(v8), 0);
        chk("t5h_cnt", 32'(cnt8), 0);
        chk("t5h_mask", 32'(mask8), 32'b010);
        chk("t5h_ts", ts8, e_ts);

        // T3: mask ORs across the window
        block8 = 1; sigs8 = 3'b001;
        step(4);
        sigs8 = 3'b100;
        step(3);
        exp_q.push_back('{mask: 3'b101, ts: cyc8});
        step(1);
        chk("t3_valid", 32'(v8), 1);
        chk("t3_mask", 32'(mask8), 32'b101);
        block8 = 0; ready8 = 1;
        step(1);
        ready8 = 0;
        chk("t3_accepts", 32'(accepts), 2);
        clear8 = 1;
        step(1);
        clear8 = 0;

        // T5: clear in COUNT wins over block_in
        block8 = 1; sigs8 = 3'b001;
        step(3);
        chk("t5c_cnt3", 32'(cnt8), 3);
        clear8 = 1;
        step(1);
        clear8 = 0; block8 = 0;
        chk("t5c_cnt0", 32'(cnt8), 0);
        chk("t5c_found", 32'(found8), 0);
        chk("t5c_mask", 32'(mask8), 32'b101);
        step(1);

        // T5: clear in REPORT withdraws valid without a handshake
        block8 = 1; sigs8 = 3'b011;
        step(7);
        e_ts = cyc8;
        step(1);
        chk("t5r_valid", 32'(v8), 1);
        chk("t5r_mask", 32'(mask8), 32'b011);
        clear8 = 1; block8 = 0;
        step(1);
        clear8 = 0;
        chk("t5r_valid0", 32'(v8), 0);
        chk("t5r_found0", 32'(found8), 0);
        chk("t5r_mask_kept", 32'(mask8), 32'b011);
        chk("t5r_ts_kept", ts8, e_ts);
        step(2);
        chk("t5r_still0", 32'(v8), 0);
        chk("sb_empty", 32'(exp_q.size()), 0);

        // T6: THRESH=1 narrow instance
        @(negedge clock);
        rst1 = 1;
        step(1);
        block1 = 1; sigs1 = 3'b100;
        step(1);
        chk("t6_valid", 32'(v1), 1);
        chk("t6_found", 32'(found1), 1);
        chk("t6_ts", 32'(ts1), 1);
        chk("t6_mask", 32'(mask1), 32'b100);
        chk("t6_cnt1", 32'(cnt1), 1);
        ready1 = 1;
        step(1);
        ready1 = 0;
        chk("t6_hold_valid", 32'(v1), 0);
        chk("t6_hold_cnt", 32'(cnt1), 1);
        step(9);
        chk("t6_sat", 32'(cnt1), 3);
        clear1 = 1; block1 = 0;
        step(1);
        clear1 = 0;
        chk("t6_clr_cnt", 32'(cnt1), 0);
        chk("t6_clr_found", 32'(found1), 0);

        k = 0;
        while ((cyc1 % 16) != 15 && k < 40) begin step(1); k++; end
        chk("t6_wait15", 32'(k < 40), 1);
        block1 = 1; sigs1 = 3'b001;
        step(1);
        chk("t6_ts15", 32'(ts1), 15);
        ready1 = 1;
        step(1);
        ready1 = 0; clear1 = 1; block1 = 0;
        step(1);
        clear1 = 0;
        k = 0;
        while ((cyc1 % 16) != 2 && k < 40) begin step(1); k++; end
        chk("t6_wait2", 32'(k < 40), 1);
        block1 = 1; sigs1 = 3'b010;
        step(1);
        block1 = 0;
        chk("t6_ts_wrap", 32'(ts1), 2);
        chk("t6_mask2", 32'(mask1), 32'b010);
        chk("t6_valid2", 32'(v1), 1);

        // async reset mid-REPORT, checked before the next edge
        #2;
        rst1 = 0;
        #1;
        chk("t6_ar_valid", 32'(v1), 0);
        chk("t6_ar_found", 32'(found1), 0);
        chk("t6_ar_cnt", 32'(cnt1), 0);
        chk("t6_ar_mask", 32'(mask1), 0);
        chk("t6_ar_ts", 32'(ts1), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
